// File: rtl/prog_mem_responder_if.sv
// Fetch and load-port signals of the program-memory responder.
// The master side is the fetch stage and the loader; the slave side is the responder.
interface prog_mem_responder_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] prog_mem_fetch_read_addr;
  logic                  stall;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic                  fetch_instr_valid;
  logic                  fetch_stall_req;
  logic                  load_start;
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_WIDTH:0]   load_count;

  modport master (
    output prog_mem_fetch_read_addr, stall, load_start, load_valid, load_data, load_last,
    input  fetch_instr, fetch_instr_valid, fetch_stall_req, load_ready, load_done,
           load_error, load_count
  );

  modport slave (
    input  prog_mem_fetch_read_addr, stall, load_start, load_valid, load_data, load_last,
    output fetch_instr, fetch_instr_valid, fetch_stall_req, load_ready, load_done,
           load_error, load_count
  );
endinterface

// File: rtl/prog_mem_responder.sv
// Instruction RAM with a registered one-cycle fetch port and a valid/ready image loader.
// The fetch pipeline is held in stall whenever the block is not in RUN.
module prog_mem_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  prog_mem_responder_if.slave    bus
);
  typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  load_error_q, load_error_d;
  logic                  load_done_q, load_done_d;
  logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Next-state and output decode; the load count doubles as the write pointer.
  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    load_error_d  = load_error_q;
    load_done_d   = 1'b0;
    fetch_instr_d = fetch_instr_q;
    fetch_valid_d = fetch_valid_q;
    wr_en         = 1'b0;
    case (state_q)
      LOAD: begin
        fetch_valid_d = 1'b0;
        if (bus.load_valid) begin
          wr_en        = 1'b1;
          load_count_d = load_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (bus.load_last) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end else if (load_count_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
            // Last slot filled without load_last: stop rather than wrap.
            state_d      = RUN;
            load_done_d  = 1'b1;
            load_error_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          wr_en = 1'b0;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_d       = LOAD;
          load_count_d  = '0;
          load_error_d  = 1'b0;
          fetch_valid_d = 1'b0;
        end else if (!bus.stall) begin
          fetch_instr_d = mem_q[bus.prog_mem_fetch_read_addr];
          fetch_valid_d = 1'b1;
        end else begin
          fetch_valid_d = fetch_valid_q;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= LOAD;
      load_count_q  <= '0;
      load_error_q  <= 1'b0;
      load_done_q   <= 1'b0;
      fetch_instr_q <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      load_error_q  <= load_error_d;
      load_done_q   <= load_done_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Image RAM: contents survive reset and reload.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem_q[load_count_q[ADDR_WIDTH-1:0]] <= bus.load_data;
    end
  end

  assign bus.fetch_instr       = fetch_instr_q;
  assign bus.fetch_instr_valid = fetch_valid_q;
  assign bus.fetch_stall_req   = (state_q != RUN);
  assign bus.load_ready        = (state_q == LOAD);
  assign bus.load_done         = load_done_q;
  assign bus.load_error        = load_error_q;
  assign bus.load_count        = load_count_q;
endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder (ADDR_WIDTH=4) with a behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_prog_mem_responder;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 2**AW;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  prog_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: image array, word count, and the run/load mode.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_loading;
  int            m_cnt;
  bit            m_err, m_done, m_valid;
  logic [DW-1:0] m_instr;

  always @(posedge clock) begin
    if (reset) begin
      m_loading = 1'b1; m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
      m_valid = 1'b0; m_instr = '0;
    end else if (m_loading) begin
      m_done = 1'b0;
      if (bus.load_valid) begin
        m_mem[m_cnt] = bus.load_data;
        m_cnt = m_cnt + 1;
        if (bus.load_last || m_cnt == DEPTH) begin
          m_loading = 1'b0;
          m_done = 1'b1;
          m_err = !bus.load_last;
        end
      end
    end else begin
      m_done = 1'b0;
      if (bus.load_start) begin
        m_loading = 1'b1; m_cnt = 0; m_err = 1'b0; m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_instr = m_mem[bus.prog_mem_fetch_read_addr];
        m_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_instr", 32'(bus.fetch_instr), 32'(m_instr));
      chk("m_valid", 32'(bus.fetch_instr_valid), 32'(m_valid));
      chk("m_stall_req", 32'(bus.fetch_stall_req), 32'(m_loading));
      chk("m_ready", 32'(bus.load_ready), 32'(m_loading));
      chk("m_done", 32'(bus.load_done), 32'(m_done));
      chk("m_error", 32'(bus.load_error), 32'(m_err));
      chk("m_count", 32'(bus.load_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last);
    bus.load_valid = 1'b1; bus.load_data = d; bus.load_last = last;
    tick();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
  endtask

  task automatic fetch(input int a);
    bus.prog_mem_fetch_read_addr = AW'(a);
    tick();
  endtask

  task automatic reload();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  initial begin
    bit gaps [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int k;
    reset = 1'b1;
    bus.prog_mem_fetch_read_addr = '0; bus.stall = 1'b0; bus.load_start = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_instr", 32'(bus.fetch_instr), 32'h0);
    chk("rst_valid", 32'(bus.fetch_instr_valid), 32'h0);
    chk("rst_stall_req", 32'(bus.fetch_stall_req), 32'h1);
    chk("rst_ready", 32'(bus.load_ready), 32'h1);
    chk("rst_count", 32'(bus.load_count), 32'h0);

    // Basic load and run
    send(16'h1111, 1'b0); send(16'h2222, 1'b0); send(16'h3333, 1'b1);
    chk("basic_done", 32'(bus.load_done), 32'h1);
    chk("basic_ready", 32'(bus.load_ready), 32'h0);
    chk("basic_stall_req", 32'(bus.fetch_stall_req), 32'h0);
    chk("basic_valid_first", 32'(bus.fetch_instr_valid), 32'h0);
    chk("basic_count", 32'(bus.load_count), 32'h3);
    fetch(1);
    chk("basic_fetch1", 32'(bus.fetch_instr), 32'h2222);
    chk("basic_done_off", 32'(bus.load_done), 32'h0);

    // Backpressure: five words with gaps in load_valid
    reload();
    chk("reload_stall_req", 32'(bus.fetch_stall_req), 32'h1);
    chk("reload_valid", 32'(bus.fetch_instr_valid), 32'h0);
    k = 0;
    for (int i = 0; i < 9; i++) begin
      if (gaps[i]) begin
        send(16'h5000 + 16'(k), k == 4);
        k++;
      end else begin
        tick();
      end
    end
    chk("bp_count", 32'(bus.load_count), 32'h5);
    bus.load_valid = 1'b1; bus.load_data = 16'hDEAD;
    fetch(4);
    chk("bp_fetch4", 32'(bus.fetch_instr), 32'h5004);
    fetch(0);
    bus.load_valid = 1'b0;
    chk("bp_no_write", 32'(bus.fetch_instr), 32'h5000);
    chk("bp_count_held", 32'(bus.load_count), 32'h5);

    // Stall hold
    bus.stall = 1'b1;
    fetch(2); tick();
    chk("stall_hold", 32'(bus.fetch_instr), 32'h5000);
    chk("stall_valid", 32'(bus.fetch_instr_valid), 32'h1);
    bus.stall = 1'b0;
    tick();
    chk("stall_release", 32'(bus.fetch_instr), 32'h5002);

    // Overflow: sixteen words, no load_last
    reload();
    for (int i = 0; i < DEPTH; i++) send(16'h6000 + 16'(i), 1'b0);
    chk("ovf_error", 32'(bus.load_error), 32'h1);
    chk("ovf_count", 32'(bus.load_count), 32'h10);
    chk("ovf_ready", 32'(bus.load_ready), 32'h0);
    bus.load_valid = 1'b1; bus.load_data = 16'hEEEE;
    fetch(15);
    bus.load_valid = 1'b0;
    chk("ovf_17th_count", 32'(bus.load_count), 32'h10);
    chk("ovf_fetch15", 32'(bus.fetch_instr), 32'h600F);
    fetch(0);
    chk("ovf_fetch0", 32'(bus.fetch_instr), 32'h6000);

    // Reload with stall high: load_start wins
    bus.stall = 1'b1;
    reload();
    bus.stall = 1'b0;
    chk("rl_stall_req", 32'(bus.fetch_stall_req), 32'h1);
    chk("rl_valid", 32'(bus.fetch_instr_valid), 32'h0);
    chk("rl_error", 32'(bus.load_error), 32'h0);
    bus.load_start = 1'b1;
    send(16'hABCD, 1'b1);
    bus.load_start = 1'b0;
    chk("rl_count", 32'(bus.load_count), 32'h1);
    fetch(0);
    chk("rl_fetch0", 32'(bus.fetch_instr), 32'hABCD);
    fetch(1);
    chk("rl_fetch1_old", 32'(bus.fetch_instr), 32'h6001);

    // Reset mid-load, with a word offered during the reset cycle
    reload();
    send(16'h7000, 1'b0); send(16'h7001, 1'b0);
    reset = 1'b1;
    send(16'h7777, 1'b0);
    reset = 1'b0;
    chk("mid_rst_instr", 32'(bus.fetch_instr), 32'h0);
    chk("mid_rst_count", 32'(bus.load_count), 32'h0);
    chk("mid_rst_ready", 32'(bus.load_ready), 32'h1);
    send(16'h8000, 1'b0); send(16'h8001, 1'b1);
    fetch(0);
    chk("mid_fetch0", 32'(bus.fetch_instr), 32'h8000);
    fetch(1);
    chk("mid_fetch1", 32'(bus.fetch_instr), 32'h8001);
    fetch(2);
    chk("mid_fetch2_kept", 32'(bus.fetch_instr), 32'h6002);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
